ctrl_io_cfg_loader: RTL

Loads a configuration frame into the `ctrl_IO` tile switch matrix, a 23-bit bank of mux selects, and drives the `ConfigBits`/`ConfigBits_N` pair.
- Accepts the frame as fixed-width words over a valid/ready handshake and assembles it in a shadow register.
- Commits all bits atomically, so the dual-rail `A_I0_t`/`A_I0_f` selects never see a partially written frame.
- Sits between the fabric configuration port and one `ctrl_IO` switch matrix instance.

---
 rtl/ctrl_io_cfg_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ctrl_io_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_io_cfg_loader
// Purpose  : Assembles a configuration frame for the ctrl_IO switch matrix
//            from fixed-width words and commits it atomically to the
//            ConfigBits / ConfigBits_N dual-rail select bank.
// Options  : define CTRL_IO_CFG_PARITY_EN to enable the even-parity frame
//            check (the padding bit above NoConfigBits carries parity).
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_io_cfg_loader #(
   parameter int NoConfigBits = 23,
   parameter int WordWidth    = 8
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    cfg_valid,
   input  logic [WordWidth-1:0]    cfg_data,
   output logic                    cfg_ready,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [NoConfigBits-1:0] ConfigBits,
   output logic [NoConfigBits-1:0] ConfigBits_N
);

   localparam int NoWords = (NoConfigBits + WordWidth - 1) / WordWidth;
   localparam int WcntW   = $clog2(NoWords) + 1;
   localparam int IdxW    = (NoConfigBits > 1) ? $clog2(NoConfigBits) : 1;
   localparam int BitW    = (WordWidth > 1) ? $clog2(WordWidth) : 1;
   localparam logic [WcntW-1:0] LastWord = WcntW'(NoWords - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      CHECK  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t                  state;
   logic [WcntW-1:0]        wcnt;
   // Only the bits that reach the switch matrix are stored; padding bits
   // are consumed solely by the parity accumulator.
   logic [NoConfigBits-1:0] shadow;
   logic                    check_ok;

`ifdef CTRL_IO_CFG_PARITY_EN
   logic parity;
   logic error_q;
   // Frame is accepted only when the XOR of every received bit is zero.
   assign check_ok = ~parity;
   assign error    = error_q;
`else
   assign check_ok = 1'b1;
   assign error    = 1'b0;
`endif

   // Frame-loading FSM; every output is registered so cfg_ready never
   // depends combinationally on cfg_valid.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         wcnt         <= '0;
         shadow       <= '0;
         ConfigBits   <= '0;
         ConfigBits_N <= '1;
         cfg_ready    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
`ifdef CTRL_IO_CFG_PARITY_EN
         parity       <= 1'b0;
         error_q      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // abort takes priority over a simultaneous start
               if (start && !abort) begin
                  state     <= LOAD;
                  wcnt      <= '0;
                  shadow    <= '0;
                  cfg_ready <= 1'b1;
                  busy      <= 1'b1;
`ifdef CTRL_IO_CFG_PARITY_EN
                  parity    <= 1'b0;
                  error_q   <= 1'b0;
`endif
               end
            end

            LOAD: begin
               if (abort) begin
                  state     <= IDLE;
                  shadow    <= '0;
                  cfg_ready <= 1'b0;
                  busy      <= 1'b0;
               end else if (cfg_valid && cfg_ready) begin
                  // Place the word at its LSB-first slot, dropping padding bits
                  for (int w = 0; w < NoWords; w++) begin
                     if (wcnt == WcntW'(w)) begin
                        for (int b = 0; b < WordWidth; b++) begin
                           if (w * WordWidth + b < NoConfigBits) begin
                              shadow[IdxW'(w * WordWidth + b)] <= cfg_data[BitW'(b)];
                           end
                        end
                     end
                  end
`ifdef CTRL_IO_CFG_PARITY_EN
                  parity <= parity ^ (^cfg_data);
`endif
                  wcnt <= wcnt + 1'b1;
                  if (wcnt == LastWord) begin
                     state     <= CHECK;
                     cfg_ready <= 1'b0;
                  end
               end
            end

            CHECK: begin
               if (abort) begin
                  state  <= IDLE;
                  shadow <= '0;
                  busy   <= 1'b0;
               end else if (check_ok) begin
                  state <= COMMIT;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
`ifdef CTRL_IO_CFG_PARITY_EN
                  error_q <= 1'b1;
`endif
               end
            end

            COMMIT: begin
               // Both rails update on the same edge so the switch matrix
               // never sees a partially written frame; abort is ignored here.
               ConfigBits   <= shadow;
               ConfigBits_N <= ~shadow;
               done         <= 1'b1;
               busy         <= 1'b0;
               state        <= IDLE;
            end

            default: begin
               state     <= IDLE;
               cfg_ready <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
